vga_scan_ctrl: RTL and testbench
================================

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 Parameter: PIPE_DLY, default 2, number of vgaclk cycles by which the sync/enable outputs are delayed to line up with the downstream tile-lookup and texture stages.
REQ-002 Port: vgaclk  input  1  pixel clock (25 MHz), all logic on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: map_x  output  4  tile column of the current pixel (0..15), valid stage 0.
REQ-005 Port: map_y  output  4  tile row of the current pixel (0..14), valid stage 0.
REQ-006 Port: x_pos  output  5  pixel column within the 32x32 tile, stage 0.
REQ-007 Port: y_pos  output  5  pixel row within the tile, stage 0.
REQ-008 Port: hs  output  1  horizontal sync, active low, delayed PIPE_DLY cycles.
REQ-009 Port: vs  output  1  vertical sync, active low, delayed PIPE_DLY cycles.
REQ-010 Port: de  output  1  display enable (visible 640x480 area), delayed PIPE_DLY cycles.
REQ-011 Port: in_field  output  1  pixel lies in the 512x480 playfield, delayed PIPE_DLY cycles.
REQ-012 Port: frame_tick  output  1  one-cycle pulse at end of each frame, undelayed.

Function
REQ-013 The block SHALL hold a 10-bit h_cnt counting 0..799 and wrapping to 0 after 799.
REQ-014 The block SHALL hold a 10-bit v_cnt that increments only when h_cnt=799 and wraps to 0 after 524.
REQ-015 Horizontal timing SHALL be: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-016 Vertical timing SHALL be: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-017 The stage-0 raw hs SHALL be 0 exactly when 656<=h_cnt<=751, and 1 otherwise.
REQ-018 The stage-0 raw vs SHALL be 0 exactly when 490<=v_cnt<=491, and 1 otherwise.
REQ-019 The stage-0 raw de SHALL be 1 exactly when h_cnt<640 and v_cnt<480.
REQ-020 The stage-0 raw in_field SHALL be 1 exactly when h_cnt<512 and v_cnt<480.
REQ-021 x_pos SHALL equal h_cnt[4:0] and y_pos SHALL equal v_cnt[4:0], decoded combinationally from the counter registers.
REQ-022 map_x SHALL equal h_cnt[8:5] when h_cnt<512 and 0 otherwise; map_y SHALL equal v_cnt[8:5] when v_cnt<480 and 0 otherwise.
REQ-023 hs, vs, de and in_field SHALL each pass through a PIPE_DLY-deep shift register; output = raw value from PIPE_DLY cycles earlier.
REQ-024 PIPE_DLY=0 SHALL connect the raw values directly; the legal range is 0..4.
REQ-025 frame_tick SHALL be 1 for exactly the one cycle in which h_cnt=799 and v_cnt=524, and 0 otherwise.
REQ-026 map/pos outputs SHALL never exceed tile range: map_x<=15, map_y<=14.

Reset
REQ-027 While rst_n=0, h_cnt and v_cnt SHALL be 0, regardless of the clock.
REQ-028 While rst_n=0, all delay-line stages SHALL be hs=1, vs=1, de=0, in_field=0, and frame_tick SHALL be 0.
REQ-029 A mid-frame reset SHALL abort the frame.
REQ-030 After reset deasserts, counting SHALL restart at (0,0) on the first rising edge.
REQ-031 After reset deasserts, the delay lines SHALL emit inactive values for PIPE_DLY cycles.

Verification
REQ-032 Scenario: release reset, run 420000 cycles -> exactly one frame_tick every 420000 cycles, first one at cycle 419999 after release.
REQ-033 Scenario: PIPE_DLY=2, sample h_cnt=656 -> hs falls 2 cycles later, stays 0 for 96 cycles, and the line period is 800.
REQ-034 Scenario: v_cnt=490, h_cnt=0 -> vs (delayed) low for exactly 1600 cycles, and de=0 for all of lines 480..524.
REQ-035 Scenario: h_cnt=511, v_cnt=479 -> map_x=15, map_y=14, x_pos=31, y_pos=31, in_field=1 two cycles later; h_cnt=512 -> map_x=0, in_field=0, de=1.
REQ-036 Scenario: assert rst_n=0 at h_cnt=300, v_cnt=200 for 3 cycles -> outputs go to inactive values immediately (asynchronously); after release, map_x=0 and x_pos=0, and de rises at cycle PIPE_DLY.
REQ-037 Scenario: PIPE_DLY=0 vs PIPE_DLY=4 -> the hs/vs/de waveforms are identical apart from a 4-cycle shift.

Source files
------------

// File: rtl/vga_scan_ctrl.sv
// 640x480@60 VGA scan timing generator with 32x32 tile-coordinate decode.
// Sync/enable outputs are delayed PIPE_DLY cycles to line up with the tile-lookup and texture stages.
module vga_scan_ctrl #(
  parameter int unsigned PIPE_DLY = 2
) (
  input  logic       vgaclk,
  input  logic       rst_n,
  output logic [3:0] map_x,
  output logic [3:0] map_y,
  output logic [4:0] x_pos,
  output logic [4:0] y_pos,
  output logic       hs,
  output logic       vs,
  output logic       de,
  output logic       in_field,
  output logic       frame_tick
);

  localparam logic [9:0] H_LAST      = 10'd799;
  localparam logic [9:0] H_VISIBLE   = 10'd640;
  localparam logic [9:0] H_FIELD     = 10'd512;
  localparam logic [9:0] H_SYNC_BEG  = 10'd656;
  localparam logic [9:0] H_SYNC_END  = 10'd751;
  localparam logic [9:0] V_LAST      = 10'd524;
  localparam logic [9:0] V_VISIBLE   = 10'd480;
  localparam logic [9:0] V_SYNC_BEG  = 10'd490;
  localparam logic [9:0] V_SYNC_END  = 10'd491;

  // Delay-line word layout is {hs, vs, de, in_field}; idle is syncs high, enables low.
  localparam logic [3:0] DL_IDLE = 4'b1100;

  if (PIPE_DLY > 4) begin : g_bad_pipe_dly
    $error("vga_scan_ctrl: PIPE_DLY must be in 0..4");
  end

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_h_field;
  logic       w_v_visible;
  logic [3:0] w_raw;
  logic [3:0] w_dly_out;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  always_comb begin
    w_h_field   = (r_h_cnt < H_FIELD);
    w_v_visible = (r_v_cnt < V_VISIBLE);
    w_raw       = DL_IDLE;
    w_raw[3]    = !((r_h_cnt >= H_SYNC_BEG) && (r_h_cnt <= H_SYNC_END));
    w_raw[2]    = !((r_v_cnt >= V_SYNC_BEG) && (r_v_cnt <= V_SYNC_END));
    w_raw[1]    = (r_h_cnt < H_VISIBLE) && w_v_visible;
    w_raw[0]    = w_h_field && w_v_visible;
  end

  assign x_pos      = r_h_cnt[4:0];
  assign y_pos      = r_v_cnt[4:0];
  assign map_x      = w_h_field   ? r_h_cnt[8:5] : '0;
  assign map_y      = w_v_visible ? r_v_cnt[8:5] : '0;
  assign frame_tick = w_h_last && w_v_last;

  if (PIPE_DLY == 0) begin : g_no_dly
    assign w_dly_out = w_raw;
  end else begin : g_dly
    // Packed shift register: newest word enters at the bottom, oldest leaves at the top.
    logic [PIPE_DLY*4-1:0] r_dl;
    logic [PIPE_DLY*4+3:0] w_dl_next;

    assign w_dl_next = {r_dl, w_raw};

    always_ff @(posedge vgaclk or negedge rst_n) begin
      if (!rst_n) begin
        r_dl <= {PIPE_DLY{DL_IDLE}};
      end else begin
        r_dl <= w_dl_next[PIPE_DLY*4-1:0];
      end
    end

    assign w_dly_out = r_dl[PIPE_DLY*4-1 -: 4];
  end

  assign hs       = w_dly_out[3];
  assign vs       = w_dly_out[2];
  assign de       = w_dly_out[1];
  assign in_field = w_dly_out[0];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench for vga_scan_ctrl: scoreboard of delayed sync/enable words for PIPE_DLY 0/2/4,
// a table of decoded positions, and hand-written reset / sync-width / frame-end sequences.
`timescale 1ns/1ps
module tb_vga_scan_ctrl;

  logic vgaclk = 1'b0;
  logic rst_n  = 1'b1;
  always #20 vgaclk = ~vgaclk;

  logic [3:0] map_x_0, map_y_0, map_x_2, map_y_2, map_x_4, map_y_4;
  logic [4:0] x_pos_0, y_pos_0, x_pos_2, y_pos_2, x_pos_4, y_pos_4;
  logic hs_0, vs_0, de_0, if_0, ft_0;
  logic hs_2, vs_2, de_2, if_2, ft_2;
  logic hs_4, vs_4, de_4, if_4, ft_4;

  vga_scan_ctrl #(.PIPE_DLY(0)) dut_0 (
    .vgaclk(vgaclk), .rst_n(rst_n), .map_x(map_x_0), .map_y(map_y_0), .x_pos(x_pos_0),
    .y_pos(y_pos_0), .hs(hs_0), .vs(vs_0), .de(de_0), .in_field(if_0), .frame_tick(ft_0));
  vga_scan_ctrl #(.PIPE_DLY(2)) dut_2 (
    .vgaclk(vgaclk), .rst_n(rst_n), .map_x(map_x_2), .map_y(map_y_2), .x_pos(x_pos_2),
    .y_pos(y_pos_2), .hs(hs_2), .vs(vs_2), .de(de_2), .in_field(if_2), .frame_tick(ft_2));
  vga_scan_ctrl #(.PIPE_DLY(4)) dut_4 (
    .vgaclk(vgaclk), .rst_n(rst_n), .map_x(map_x_4), .map_y(map_y_4), .x_pos(x_pos_4),
    .y_pos(y_pos_4), .hs(hs_4), .vs(vs_4), .de(de_4), .in_field(if_4), .frame_tick(ft_4));

  typedef logic [3:0] sig4_t;  // {hs, vs, de, in_field}
  localparam sig4_t INACT = 4'b1100;

  typedef struct {
    int    h;
    int    v;
    int    mx;
    int    my;
    int    xp;
    int    yp;
    sig4_t raw;
    int    ft;
  } vec_t;

  int    n_total = 0;
  int    n_bad   = 0;
  int    m_h     = 0;
  int    m_v     = 0;
  sig4_t q0[$];
  sig4_t q2[$];
  sig4_t q4[$];
  logic [9:0] jh, jv;
  vec_t  vecs[16];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (model h=%0d v=%0d)", nm, act, exp, m_h, m_v);
    end
  endtask

  function automatic sig4_t raw_of(input int h, input int v);
    sig4_t r;
    r[3] = !(h >= 656 && h <= 751);
    r[2] = !(v >= 490 && v <= 491);
    r[1] = (h < 640) && (v < 480);
    r[0] = (h < 512) && (v < 480);
    return r;
  endfunction

  task automatic reset_model();
    m_h = 0;
    m_v = 0;
    q0.delete();
    q2.delete();
    q4.delete();
    repeat (2) q2.push_back(INACT);
    repeat (4) q4.push_back(INACT);
  endtask

  task automatic advance();
    if (m_h == 799) begin
      m_h = 0;
      m_v = (m_v == 524) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
  endtask

  task automatic chk_stage0(input string tag, input logic [3:0] mx, input logic [3:0] my,
                            input logic [4:0] xp, input logic [4:0] yp);
    chk({tag, "_map_x"}, int'(mx), (m_h < 512) ? m_h / 32 : 0);
    chk({tag, "_map_y"}, int'(my), (m_v < 480) ? m_v / 32 : 0);
    chk({tag, "_x_pos"}, int'(xp), m_h % 32);
    chk({tag, "_y_pos"}, int'(yp), m_v % 32);
  endtask

  // Called at a negedge: push this cycle's raw word, pop the word each delay line should now show.
  task automatic check_now();
    sig4_t r;
    int    exp_ft;
    r = raw_of(m_h, m_v);
    q0.push_back(r);
    q2.push_back(r);
    q4.push_back(r);
    chk("dly0_word", int'({hs_0, vs_0, de_0, if_0}), int'(q0.pop_front()));
    chk("dly2_word", int'({hs_2, vs_2, de_2, if_2}), int'(q2.pop_front()));
    chk("dly4_word", int'({hs_4, vs_4, de_4, if_4}), int'(q4.pop_front()));
    chk_stage0("d0", map_x_0, map_y_0, x_pos_0, y_pos_0);
    chk_stage0("d2", map_x_2, map_y_2, x_pos_2, y_pos_2);
    chk_stage0("d4", map_x_4, map_y_4, x_pos_4, y_pos_4);
    exp_ft = (rst_n && m_h == 799 && m_v == 524) ? 1 : 0;
    chk("ft_0", int'(ft_0), exp_ft);
    chk("ft_2", int'(ft_2), exp_ft);
    chk("ft_4", int'(ft_4), exp_ft);
  endtask

  task automatic step();
    @(posedge vgaclk);
    advance();
    @(negedge vgaclk);
    check_now();
  endtask

  // Teleport all counters at a negedge; delay-line contents are left untouched.
  task jump(input int h, input int v);
    jh = 10'(h);
    jv = 10'(v);
    force dut_0.r_h_cnt = jh;
    force dut_0.r_v_cnt = jv;
    force dut_2.r_h_cnt = jh;
    force dut_2.r_v_cnt = jv;
    force dut_4.r_h_cnt = jh;
    force dut_4.r_v_cnt = jv;
    release dut_0.r_h_cnt;
    release dut_0.r_v_cnt;
    release dut_2.r_h_cnt;
    release dut_2.r_v_cnt;
    release dut_4.r_h_cnt;
    release dut_4.r_v_cnt;
    m_h = h;
    m_v = v;
    void'(q2.pop_back());
    q2.push_back(raw_of(h, v));
    void'(q4.pop_back());
    q4.push_back(raw_of(h, v));
  endtask

  initial begin
    int   fall0, fall1, hs_low, de_cnt, if_cnt, vs_low, ft_cnt;
    logic prev_hs;

    vecs[0]  = '{  0,   0,  0,  0,  0,  0, 4'b1111, 0};
    vecs[1]  = '{511, 479, 15, 14, 31, 31, 4'b1111, 0};
    vecs[2]  = '{512, 479,  0, 14,  0, 31, 4'b1110, 0};
    vecs[3]  = '{639,   0,  0,  0, 31,  0, 4'b1110, 0};
    vecs[4]  = '{640,   0,  0,  0,  0,  0, 4'b1100, 0};
    vecs[5]  = '{655, 100,  0,  3, 15,  4, 4'b1100, 0};
    vecs[6]  = '{656, 100,  0,  3, 16,  4, 4'b0100, 0};
    vecs[7]  = '{751, 100,  0,  3, 15,  4, 4'b0100, 0};
    vecs[8]  = '{752, 100,  0,  3, 16,  4, 4'b1100, 0};
    vecs[9]  = '{100, 480,  3,  0,  4,  0, 4'b1100, 0};
    vecs[10] = '{100, 490,  3,  0,  4, 10, 4'b1000, 0};
    vecs[11] = '{100, 491,  3,  0,  4, 11, 4'b1000, 0};
    vecs[12] = '{100, 492,  3,  0,  4, 12, 4'b1100, 0};
    vecs[13] = '{799, 523,  0,  0, 31, 11, 4'b1100, 0};
    vecs[14] = '{799, 524,  0,  0, 31, 12, 4'b1100, 1};
    vecs[15] = '{300, 200,  9,  6, 12,  8, 4'b1111, 0};

    // Power-on reset.
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge vgaclk);
      reset_model();
      check_now();
    end
    chk("rst_hs", int'(hs_2), 1);
    chk("rst_vs", int'(vs_2), 1);
    chk("rst_de", int'(de_2), 0);
    chk("rst_in_field", int'(if_2), 0);
    rst_n = 1'b1;

    // Two full lines: hsync falls 2 cycles after h_cnt=656, lasts 96 cycles, repeats every 800.
    fall0   = -1;
    fall1   = -1;
    hs_low  = 0;
    prev_hs = 1'b1;
    for (int k = 1; k <= 1700; k++) begin
      step();
      if (!hs_2) hs_low++;
      if (prev_hs && !hs_2) begin
        if (fall0 < 0) fall0 = k;
        else if (fall1 < 0) fall1 = k;
      end
      prev_hs = hs_2;
    end
    chk("hs_fall_first", fall0, 658);
    chk("hs_fall_second", fall1, 1458);
    chk("hs_low_cycles", hs_low, 192);

    // Decode table.
    for (int i = 0; i < 16; i++) begin
      jump(vecs[i].h, vecs[i].v);
      #1;
      chk("tbl_map_x", int'(map_x_2), vecs[i].mx);
      chk("tbl_map_y", int'(map_y_2), vecs[i].my);
      chk("tbl_x_pos", int'(x_pos_2), vecs[i].xp);
      chk("tbl_y_pos", int'(y_pos_2), vecs[i].yp);
      chk("tbl_raw_word", int'({hs_0, vs_0, de_0, if_0}), int'(vecs[i].raw));
      chk("tbl_frame_tick", int'(ft_2), vecs[i].ft);
      repeat (5) step();
    end

    // Vertical blanking: lines 480..524 then wrap into the next frame.
    jump(0, 480);
    de_cnt = 0;
    if_cnt = 0;
    vs_low = 0;
    ft_cnt = 0;
    for (int k = 1; k <= 36001; k++) begin
      step();
      if (ft_2) ft_cnt++;
      if (k >= 2) begin
        if (de_2) de_cnt++;
        if (if_2) if_cnt++;
        if (!vs_2) vs_low++;
      end
    end
    chk("vblank_de_cycles", de_cnt, 0);
    chk("vblank_in_field_cycles", if_cnt, 0);
    chk("vs_low_cycles", vs_low, 1600);
    chk("frame_tick_count", ft_cnt, 1);

    // Mid-frame asynchronous reset.
    jump(300, 200);
    repeat (5) step();
    chk("pre_rst_de", int'(de_2), 1);
    @(posedge vgaclk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_hs", int'(hs_2), 1);
    chk("async_vs", int'(vs_2), 1);
    chk("async_de", int'(de_2), 0);
    chk("async_in_field", int'(if_2), 0);
    chk("async_de_d4", int'(de_4), 0);
    chk("async_map_x", int'(map_x_2), 0);
    chk("async_x_pos", int'(x_pos_2), 0);
    chk("async_ft", int'(ft_2), 0);
    repeat (3) begin
      @(negedge vgaclk);
      reset_model();
      check_now();
    end
    rst_n = 1'b1;
    #1;
    chk("rel_map_x", int'(map_x_2), 0);
    chk("rel_x_pos", int'(x_pos_2), 0);
    step();
    chk("rel_de_cyc1", int'(de_2), 0);
    step();
    chk("rel_de_cyc2", int'(de_2), 1);
    repeat (4) step();
    chk("rel_de4_cyc6", int'(de_4), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
